// File: rtl/pipe_skid_stage_pkg.sv
// Shared state encoding and constants for the pipe_skid_stage flow-controlled pipeline register.
package pipe_skid_stage_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'b00,
    PIPE_BUSY  = 2'b01,
    PIPE_FULL  = 2'b10
  } pipe_state_t;

  localparam int unsigned STALL_CNT_W = 32;

  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    case (s)
      PIPE_BUSY: return 2'd1;
      PIPE_FULL: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_stage_stall_cnt.sv
// pipe_stall_cnt: saturating 32-bit event counter, cleared only by synchronous reset.
module pipe_stall_cnt
  import pipe_skid_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_inc,
  output logic [STALL_CNT_W-1:0] o_cnt
);

  logic [STALL_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + STALL_CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline stage with 2-entry skid buffer, synchronous flush and bubble insertion.
// Optional stall counter output enabled by macro PIPE_SKID_STALL_CNT_EN.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int unsigned       DATA_W     = 64,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        occupancy_o
`ifdef PIPE_SKID_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  pipe_state_t       r_state, w_state_nxt;
  logic [DATA_W-1:0] r_main, w_main_nxt;
  logic [DATA_W-1:0] r_skid, w_skid_nxt;
  logic              w_in_fire;
  logic              w_out_fire;

  // Handshake outputs decode only the state register, so ready never depends on out_ready_i.
  assign in_ready_o  = (r_state != PIPE_FULL);
  assign out_valid_o = (r_state != PIPE_EMPTY);
  assign out_data_o  = r_main;
  assign occupancy_o = state_occupancy(r_state);

  assign w_in_fire  = in_valid_i & in_ready_o;
  assign w_out_fire = out_valid_o & out_ready_i;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush_i) begin
      w_state_nxt = PIPE_EMPTY;
      w_main_nxt  = BUBBLE_VAL;
      w_skid_nxt  = BUBBLE_VAL;
    end else begin
      case (r_state)
        PIPE_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = PIPE_BUSY;
            w_main_nxt  = in_data_i;
          end
        end
        PIPE_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data_i;
          end else if (w_in_fire) begin
            w_state_nxt = PIPE_FULL;
            w_skid_nxt  = in_data_i;
          end else if (w_out_fire) begin
            w_state_nxt = PIPE_EMPTY;
            w_main_nxt  = BUBBLE_VAL;
          end
        end
        PIPE_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = PIPE_BUSY;
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE_VAL;
          end
        end
        default: begin
          w_state_nxt = PIPE_EMPTY;
          w_main_nxt  = BUBBLE_VAL;
          w_skid_nxt  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PIPE_EMPTY;
      r_main  <= BUBBLE_VAL;
      r_skid  <= BUBBLE_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

`ifdef PIPE_SKID_STALL_CNT_EN
  pipe_stall_cnt u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (out_valid_o & ~out_ready_i),
    .o_cnt (stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: directed plan followed by randomized traffic.
module tb_pipe_skid_stage;

  localparam int unsigned       DATA_W = 64;
  localparam logic [DATA_W-1:0] BUBBLE = 64'hBBBB_0000_0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i = '0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [DATA_W-1:0] out_data_o;
  logic [1:0]        occupancy_o;
`ifdef PIPE_SKID_STALL_CNT_EN
  logic [31:0]       stall_cnt_o;
  longint unsigned   stall_model = 0;
`endif

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_skid_stage #(
    .DATA_W     (DATA_W),
    .BUBBLE_VAL (BUBBLE)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .occupancy_o (occupancy_o)
`ifdef PIPE_SKID_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt_o)
`endif
  );

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: 1 time unit after the negedge, outputs reflect the last posedge and this cycle's inputs.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
`ifdef PIPE_SKID_STALL_CNT_EN
      stall_model = 0;
`endif
    end else begin
      chk("occupancy", DATA_W'(occupancy_o), DATA_W'(exp_q.size()));
      chk("in_ready", DATA_W'(in_ready_o), DATA_W'(exp_q.size() < 2));
      chk("out_valid", DATA_W'(out_valid_o), DATA_W'(exp_q.size() != 0));
      if (exp_q.size() == 0) chk("bubble", out_data_o, BUBBLE);
`ifdef PIPE_SKID_STALL_CNT_EN
      chk("stall_cnt", DATA_W'(stall_cnt_o), DATA_W'(stall_model));
      if (out_valid_o && !out_ready_i && stall_model < 64'hFFFF_FFFF) stall_model++;
`endif
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", DATA_W'(out_valid_o), '0);
        end else begin
          chk("out_data", out_data_o, exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        chk("head_stable", out_data_o, exp_q[0]);
      end
      if (flush_i) exp_q.delete();
    end
  end

  // Driver: inputs change on the negedge; an accepted item is queued after the monitor has popped.
  task automatic step(input logic r, input logic v, input logic [DATA_W-1:0] d,
                      input logic rdy, input logic fl);
    int unsigned pre_size;
    @(negedge clk);
    rst         = r;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = rdy;
    flush_i     = fl;
    pre_size    = exp_q.size();
    #2;
    if (!r && v && !fl && pre_size < 2) exp_q.push_back(d);
  endtask

  initial begin
    // reset with a valid offer that must be ignored
    step(1'b1, 1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0);
    step(1'b1, 1'b1, 64'hDEAD_BEEF, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    // streaming
    for (int unsigned i = 1; i <= 3; i++) step(1'b0, 1'b1, DATA_W'(i), 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    // back-pressure and skid
    step(1'b0, 1'b1, 64'hA, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hB, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hC, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hC, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 64'hC, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    // flush while FULL
    step(1'b0, 1'b1, 64'hE, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hF, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'hD, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    // flush while BUSY with an acceptable input
    step(1'b0, 1'b1, 64'h7, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h8, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    // simultaneous fire in BUSY
    step(1'b0, 1'b1, 64'h10, 1'b0, 1'b0);
    step(1'b0, 1'b1, 64'h11, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    // five stall cycles then release
    step(1'b0, 1'b1, 64'h20, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    // randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) != 0,
           {$urandom, $urandom},
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0);
    end
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
